// File: rtl/lifo_cmd_issuer.sv
// lifo_cmd_issuer: turns client push/pop handshakes into registered {opcode,data} LIFO commands
//   and returns each popped word as a one-cycle response.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   push_valid/push_data/push_ready   client push handshake
//   pop_valid/pop_ready       client pop handshake
//   rsp_valid/rsp_data        one-cycle popped-word response
//   lifo_full, lifo_data_out  LIFO status and data output
//   vector_out                registered {opcode,data} to the LIFO
//   stat_push, stat_pop       saturating accept counters (only with LIFO_CMD_STATS_EN)
// Optional feature macro: LIFO_CMD_STATS_EN
module lifo_cmd_issuer #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_ENTRIES  = 4,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               push_valid,
    input  logic [DATA_WIDTH-1:0]              push_data,
    output logic                               push_ready,
    input  logic                               pop_valid,
    output logic                               pop_ready,
    output logic                               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    input  logic                               lifo_full,
    input  logic [DATA_WIDTH-1:0]              lifo_data_out,
`ifdef LIFO_CMD_STATS_EN
    output logic [15:0]                        stat_push,
    output logic [15:0]                        stat_pop,
`endif
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out
);
    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam logic [OPCODE_WIDTH-1:0] OP_POP  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH = OPCODE_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, PUSH, POP, POP_WAIT} state_t;

    state_t                             state_q, state_d;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vec_q, vec_d;
    logic                               rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]              rsp_data_q, rsp_data_d;
    logic [CW-1:0]                      count_q, count_d;
    logic                               prio_q, prio_d; // 0: push wins a contest, 1: pop wins
    logic                               can_push, can_pop, push_acc, pop_acc, contested;

    always_comb begin
        can_push   = state_q != POP && count_q < CW'(NUM_ENTRIES) && !lifo_full;
        can_pop    = state_q != POP && count_q != '0;
        // each ready is masked only by the other side's request, never by its own valid
        push_ready = can_push && !(pop_valid && can_pop && prio_q);
        pop_ready  = can_pop && !(push_valid && can_push && !prio_q);
        push_acc   = push_valid && push_ready;
        pop_acc    = pop_valid && pop_ready;
        contested  = push_valid && pop_valid && can_push && can_pop;
        state_d    = state_q == POP ? POP_WAIT : push_acc ? PUSH : pop_acc ? POP : IDLE;
        vec_d      = push_acc ? {OP_PUSH, push_data} :
                     pop_acc  ? {OP_POP, {DATA_WIDTH{1'b0}}} : '0;
        // the LIFO presents the popped word one cycle after the POP command
        rsp_valid_d = state_q == POP_WAIT;
        rsp_data_d  = state_q == POP_WAIT ? lifo_data_out : rsp_data_q;
        count_d     = push_acc ? count_q + CW'(1) : pop_acc ? count_q - CW'(1) : count_q;
        prio_d      = contested ? !prio_q : prio_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            count_q     <= '0;
            prio_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
        end
    end

    assign vector_out = vec_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

`ifdef LIFO_CMD_STATS_EN
    logic [15:0] stat_push_q, stat_push_d, stat_pop_q, stat_pop_d;

    always_comb begin
        stat_push_d = push_acc && stat_push_q != 16'hFFFF ? stat_push_q + 16'd1 : stat_push_q;
        stat_pop_d  = pop_acc && stat_pop_q != 16'hFFFF ? stat_pop_q + 16'd1 : stat_pop_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_push_q <= '0;
            stat_pop_q  <= '0;
        end else begin
            stat_push_q <= stat_push_d;
            stat_pop_q  <= stat_pop_d;
        end
    end

    assign stat_push = stat_push_q;
    assign stat_pop  = stat_pop_q;
`endif
endmodule

// File: tb/tb_lifo_cmd_issuer.sv
// tb_lifo_cmd_issuer: randomized bench for lifo_cmd_issuer against a stack-based reference model.
module tb_lifo_cmd_issuer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       push_valid = 1'b0, pop_valid = 1'b0, extra_full = 1'b0;
    logic [3:0] push_data = '0;
    logic       push_ready, pop_ready, rsp_valid, lifo_full;
    logic [3:0] rsp_data, lifo_data_out;
    logic [5:0] vector_out;
`ifdef LIFO_CMD_STATS_EN
    logic [15:0] stat_push, stat_pop;
`endif

    always #5 clk = ~clk;

    lifo_cmd_issuer dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .lifo_full(lifo_full), .lifo_data_out(lifo_data_out),
`ifdef LIFO_CMD_STATS_EN
        .stat_push(stat_push), .stat_pop(stat_pop),
`endif
        .vector_out(vector_out)
    );

    // attached LIFO: executes whatever command vector_out carries
    logic [3:0] env_q[$];
    int         env_sz = 0;
    always @(posedge clk) begin
        if (!reset_n) begin
            env_q.delete();
            lifo_data_out <= '0;
        end else if (vector_out[5:4] == 2'b10) begin
            env_q.push_back(vector_out[3:0]);
        end else if (vector_out[5:4] == 2'b01 && env_q.size() > 0) begin
            lifo_data_out <= env_q.pop_back();
        end
        env_sz = env_q.size();
    end
    assign lifo_full = (env_sz >= 4) || extra_full;

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: accepted pushes live in a stack; a pop is busy for one extra cycle
    // and its word comes back two edges after the accept
    logic [3:0] m_stack[$];
    int         m_cnt, m_sp, m_sq;
    bit         m_prio, m_busy;
    bit  [2:0]  m_pipe;
    logic [5:0] m_vec;
    logic [3:0] m_pend, m_rsp;

    task automatic model_reset();
        m_stack.delete();
        m_cnt = 0; m_sp = 0; m_sq = 0;
        m_prio = 0; m_busy = 0; m_pipe = '0;
        m_vec = '0; m_pend = '0; m_rsp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; push_valid = 0; pop_valid = 0; extra_full = 0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
    endtask

    task automatic cycle(input bit pv, input logic [3:0] pd, input bit qv, input bit xf);
        bit cp, cq, gp, gq, con;
        @(negedge clk);
        reset_n = 1'b1; push_valid = pv; push_data = pd; pop_valid = qv; extra_full = xf;
        #1;
        cp  = !m_busy && m_cnt < 4 && !lifo_full;
        cq  = !m_busy && m_cnt > 0;
        con = pv && qv && cp && cq;
        gp  = con ? !m_prio : pv && cp;
        gq  = con ? m_prio : qv && cq;
        check("push_ready", push_ready, cp && !(qv && cq && m_prio));
        check("pop_ready", pop_ready, cq && !(pv && cp && !m_prio));
        check("vector_out", vector_out, m_vec);
        check("rsp_valid", rsp_valid, m_pipe[2]);
        check("rsp_data", rsp_data, m_rsp);
`ifdef LIFO_CMD_STATS_EN
        check("stat_push", stat_push, m_sp);
        check("stat_pop", stat_pop, m_sq);
`endif
        @(posedge clk);
        if (m_pipe[1]) m_rsp = m_pend;
        m_pipe = {m_pipe[1:0], gq};
        m_vec  = gp ? {2'b10, pd} : gq ? 6'b01_0000 : 6'b0;
        if (gp) begin
            m_stack.push_back(pd);
            m_cnt++;
            if (m_sp < 16'hFFFF) m_sp++;
        end
        if (gq) begin
            m_pend = m_stack.pop_back();
            m_cnt--;
            if (m_sq < 16'hFFFF) m_sq++;
        end
        m_busy = gq;
        if (con) m_prio = !m_prio;
    endtask

    initial begin
        logic [3:0] seq [4];
        seq = '{4'h3, 4'h7, 4'hA, 4'hF};
        model_reset();
        do_reset();
        cycle(0, 0, 0, 0);
        check("reset_vec", vector_out, 6'b00_0000);
        check("reset_push_ready", push_ready, 1);
        check("reset_pop_ready", pop_ready, 0);
        // four consecutive pushes fill the depth
        for (int i = 0; i < 4; i++) cycle(1, seq[i], 0, 0);
        cycle(1, 4'h1, 0, 0);
        check("full_push_ready", push_ready, 0);
        check("last_push_vec", vector_out, 6'b10_1111);
        // single pop returns the last pushed word
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("pop_rsp_data", rsp_data, 4'hF);
        check("push_ready_after_pop", push_ready, 1);
        // drain to two entries, then hold both requests high
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, 4'($urandom), 1, 0);
        // reset while the pop response is still pending
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0);
        check("rst_wait_rsp_valid", rsp_valid, 0);
        check("rst_wait_vec", vector_out, 6'b0);
        check("rst_wait_pop_ready", pop_ready, 0);
        // randomized traffic with occasional external full and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle(1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
